guess_entry_ctrl: RTL and testbench
===================================

# guess_entry_ctrl

Host/player-side front end for the hangman game core. Takes one-cycle key strobes from the keypad/UART receiver and runs in three phases. In LOAD, it assembles the 5-letter secret word into `setWord`. It then starts the game with a one-cycle `toggle_state` pulse. In PLAY, it feeds validated, de-duplicated guesses onto `guess`, paced by the core's `game_rdy`/`red_busy` outputs, and stops at win/lose.

## Interface
- No parameters.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset; asynchronous and active-high.
- `key_data` in 8: ASCII key code, valid when `key_valid`=1.
- `key_valid` in 1: one-cycle key strobe.
- `game_rdy` in 1: game core ready; 1 in its SET state and for one cycle at the end of each guess evaluation.
- `red_busy` in 1: game core evaluating.
- `green` in 1: game core win indicator.
- `red` in 1: game core lose indicator.
- `setWord` out 40: secret word; first letter in [39:32], fifth letter in [7:0].
- `toggle_state` out 1: one-cycle start pulse to the game core.
- `guess` out 8: current guess (uppercase ASCII), held stable between issues.
- `entry_count` out 3: letters currently in `setWord` (0..5).
- `guessed_mask` out 26: bit i set means letter 'A'+i has been accepted as a guess.
- `phase` out 2: 0=LOAD, 1=ARM, 2=PLAY, 3=DONE.
- `reject` out 1: one-cycle pulse when a key is refused.
- `dropped` out 1: one-cycle pulse when an accepted guess overwrote an unissued pending guess.

## Operation
- Key normalisation: 0x61–0x7A map to 0x41–0x5A by subtracting 0x20. 0x41–0x5A are letters. 0x08 is BKSP. 0x0D is ENTER. Every other code is refused with `reject`.
- LOAD:
  - Letter with count<5: `setWord <= {setWord[31:0], letter}`, count+1.
  - Letter with count=5: `reject`.
  - BKSP with count>0: `setWord <= {8'h00, setWord[39:8]}`, count−1.
  - BKSP with count=0: `reject`.
  - ENTER with count=5: go to ARM.
  - ENTER with count<5: `reject`.
- ARM:
  - All keys give `reject`.
  - When `game_rdy`=1 and `red_busy`=0, pulse `toggle_state` for exactly one cycle, clear `slot_free`, and go to PLAY.
  - `setWord` is frozen from ARM onward.
- PLAY:
  - Letter whose mask bit is 0: set the mask bit, load `pend`, set `pend_valid`. If `pend_valid` was already 1, overwrite `pend` and pulse `dropped`; the overwritten letter's mask bit stays set.
  - Letter whose mask bit is 1, BKSP, or ENTER: `reject`, with no state change.
  - `slot_free` is set on any cycle with `game_rdy`=1. It is cleared when a guess issues.
  - Issue: when `pend_valid`=1 and `slot_free`=1, set `guess <= pend` and clear `pend_valid` and `slot_free`.
  - Duplicate rejection guarantees every issued guess differs from the previous one. The game core detects a new guess by value change.
  - `green`=1 or `red`=1 sampled in PLAY: go to DONE and discard the pending guess.
- DONE:
  - All keys give `reject`.
  - Outputs hold until `rst`; there is no other exit.
- Simultaneous events:
  - A new key and an issue in the same cycle: the issue uses the old `pend`, and the new letter becomes the next `pend` with no `dropped` pulse.
  - `slot_free` clear takes priority over set.
- Reset values, asserted at any time including mid-game:
  - phase=LOAD, `setWord`=0, `entry_count`=0, `guess`=0x00, `toggle_state`=0.
  - `guessed_mask`=0, `reject`=0, `dropped`=0, `pend_valid`=0, `slot_free`=0.

## Timing
- All outputs are registered and change only on the rising edge of `clk`, except on asynchronous reset.
- `key_valid` at edge N: `setWord`, `entry_count` and `guessed_mask` update at edge N, and `reject`/`dropped` are high during cycle N+1.
- Guess latency: `key_valid` at edge N gives `pend_valid` at N. `guess` updates at the first edge after N where `slot_free`=1, minimum N+1.
- `toggle_state` is high for exactly one cycle per reset.
- At most one guess is issued per game-core `game_rdy` pulse.

## Test plan
- Reset mid-PLAY: assert `rst` asynchronously → phase=0, `setWord`=0, `guess`=0, mask=0 immediately, with no clock needed.
- Word entry: keys "h","E","L","L","O", then ENTER, with `game_rdy`=1 → `setWord`=0x48454C4C4F, `entry_count`=5, and one `toggle_state` pulse.
- Edit boundaries:
  - Key stream "AB", BKSP, BKSP, BKSP → the third BKSP gives `reject`, count=0.
  - 6th letter → `reject`.
  - ENTER at count=4 → `reject`.
- Guess pacing: in PLAY with `slot_free`, key "L" → `guess`=0x4C one edge later and mask bit 11 set.
  - Key "E" while `game_rdy`=0 is held pending.
  - `game_rdy` pulse → `guess`=0x45 on the next edge.
- Duplicate/invalid: a second "L", "7", and ENTER in PLAY → three `reject` pulses; `guess` and mask unchanged.
- Overwrite and end:
  - Two new letters while busy → one `dropped` pulse, and the last letter issues.
  - `green`=1 → phase=3, and further keys give `reject`.

Source files
------------

// File: rtl/guess_entry_ctrl.sv
// Host/player front end for the hangman core: assembles the secret word, arms the
// core with a start pulse, then issues validated, de-duplicated guesses paced by the core.
module guess_entry_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  key_data,
  input  logic        key_valid,
  input  logic        game_rdy,
  input  logic        red_busy,
  input  logic        green,
  input  logic        red,
  output logic [39:0] setWord,
  output logic        toggle_state,
  output logic [7:0]  guess,
  output logic [2:0]  entry_count,
  output logic [25:0] guessed_mask,
  output logic [1:0]  phase,
  output logic        reject,
  output logic        dropped
);

  localparam int unsigned KeyW       = 8;
  localparam int unsigned WordW      = 40;
  localparam int unsigned CountW     = 3;
  localparam int unsigned NumLetters = 26;
  localparam int unsigned IdxW       = 5;
  localparam int unsigned WordLen    = 5;

  localparam logic [KeyW-1:0] KeyBksp  = 8'h08;
  localparam logic [KeyW-1:0] KeyEnter = 8'h0D;

  typedef enum logic [1:0] {
    PH_LOAD = 2'd0,
    PH_ARM  = 2'd1,
    PH_PLAY = 2'd2,
    PH_DONE = 2'd3
  } phase_e;

  phase_e                  state_q;
  logic [WordW-1:0]        setword_q;
  logic [CountW-1:0]       count_q;
  logic [KeyW-1:0]         guess_q;
  logic                    toggle_q;
  logic [NumLetters-1:0]   mask_q;
  logic                    reject_q;
  logic                    dropped_q;
  logic [KeyW-1:0]         pend_q;
  logic                    pend_valid_q;
  logic                    slot_free_q;

  logic [KeyW-1:0]         key_norm;
  logic                    is_letter;
  logic                    is_bksp;
  logic                    is_enter;
  logic [IdxW-1:0]         letter_idx;
  logic [NumLetters-1:0]   letter_bit;
  logic                    letter_seen;
  logic                    word_full;
  logic                    word_empty;
  logic                    issue;

  // Key decode: fold lowercase onto uppercase, classify, and look up the guessed set.
  always_comb begin
    key_norm = key_data;
    if (key_data >= 8'h61 && key_data <= 8'h7A) begin
      key_norm = key_data - 8'h20;
    end
    is_letter   = (key_norm >= 8'h41) && (key_norm <= 8'h5A);
    is_bksp     = (key_data == KeyBksp);
    is_enter    = (key_data == KeyEnter);
    letter_idx  = IdxW'(key_norm - 8'h41);
    letter_bit  = NumLetters'(1) << letter_idx;
    letter_seen = is_letter && ((mask_q & letter_bit) != '0);
    word_full   = (count_q == CountW'(WordLen));
    word_empty  = (count_q == '0);
    issue       = pend_valid_q && slot_free_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= PH_LOAD;
      setword_q    <= '0;
      count_q      <= '0;
      guess_q      <= '0;
      toggle_q     <= 1'b0;
      mask_q       <= '0;
      reject_q     <= 1'b0;
      dropped_q    <= 1'b0;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      slot_free_q  <= 1'b0;
    end else begin
      reject_q  <= 1'b0;
      dropped_q <= 1'b0;
      toggle_q  <= 1'b0;

      case (state_q)
        PH_LOAD: begin
          if (key_valid) begin
            if (is_letter) begin
              if (!word_full) begin
                setword_q <= {setword_q[WordW-KeyW-1:0], key_norm};
                count_q   <= count_q + CountW'(1);
              end else begin
                reject_q <= 1'b1;
              end
            end else if (is_bksp) begin
              if (!word_empty) begin
                setword_q <= {KeyW'(0), setword_q[WordW-1:KeyW]};
                count_q   <= count_q - CountW'(1);
              end else begin
                reject_q <= 1'b1;
              end
            end else if (is_enter && word_full) begin
              state_q <= PH_ARM;
            end else begin
              reject_q <= 1'b1;
            end
          end
        end

        // Wait for the core to sit idle in its SET state, then kick it once.
        PH_ARM: begin
          if (key_valid) begin
            reject_q <= 1'b1;
          end
          if (game_rdy && !red_busy) begin
            toggle_q    <= 1'b1;
            slot_free_q <= 1'b0;
            state_q     <= PH_PLAY;
          end
        end

        PH_PLAY: begin
          if (green || red) begin
            state_q      <= PH_DONE;
            pend_valid_q <= 1'b0;
            if (key_valid) begin
              reject_q <= 1'b1;
            end
          end else begin
            if (game_rdy) begin
              slot_free_q <= 1'b1;
            end
            // Issue consumes the old pending letter; the clear wins over a same-cycle ready.
            if (issue) begin
              guess_q      <= pend_q;
              pend_valid_q <= 1'b0;
              slot_free_q  <= 1'b0;
            end
            if (key_valid) begin
              if (is_letter && !letter_seen) begin
                mask_q       <= mask_q | letter_bit;
                pend_q       <= key_norm;
                pend_valid_q <= 1'b1;
                if (pend_valid_q && !issue) begin
                  dropped_q <= 1'b1;
                end
              end else begin
                reject_q <= 1'b1;
              end
            end
          end
        end

        PH_DONE: begin
          if (key_valid) begin
            reject_q <= 1'b1;
          end
        end

        default: begin
          state_q <= PH_LOAD;
        end
      endcase
    end
  end

  assign setWord      = setword_q;
  assign toggle_state = toggle_q;
  assign guess        = guess_q;
  assign entry_count  = count_q;
  assign guessed_mask = mask_q;
  assign phase        = state_q;
  assign reject       = reject_q;
  assign dropped      = dropped_q;

endmodule

// File: tb/tb_guess_entry_ctrl.sv
// Bench for guess_entry_ctrl: directed vector table, hand-written PLAY sequences,
// and randomized games checked against a word-queue / letter-array model.
module tb_guess_entry_ctrl;

  logic        clk;
  logic        rst;
  logic [7:0]  key_data;
  logic        key_valid;
  logic        game_rdy;
  logic        red_busy;
  logic        green;
  logic        red;
  logic [39:0] setWord;
  logic        toggle_state;
  logic [7:0]  guess;
  logic [2:0]  entry_count;
  logic [25:0] guessed_mask;
  logic [1:0]  phase;
  logic        reject;
  logic        dropped;

  int total = 0;
  int bad   = 0;

  guess_entry_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .key_data     (key_data),
    .key_valid    (key_valid),
    .game_rdy     (game_rdy),
    .red_busy     (red_busy),
    .green        (green),
    .red          (red),
    .setWord      (setWord),
    .toggle_state (toggle_state),
    .guess        (guess),
    .entry_count  (entry_count),
    .guessed_mask (guessed_mask),
    .phase        (phase),
    .reject       (reject),
    .dropped      (dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          kv;
    logic [7:0]  key;
    bit          rdy;
    bit          busy;
    logic [1:0]  ph;
    logic [2:0]  cnt;
    logic [39:0] word;
    bit          rej;
    bit          tog;
  } vec_t;

  // Behavioural model state
  int         m_phase;
  logic [7:0] m_word[$];
  bit         m_guessed[26];
  int         m_pend;
  bit         m_slot;
  logic [7:0] m_guess;
  bit         m_rej, m_drop, m_tog;

  function automatic logic [127:0] dut_vec();
    return 128'({phase, entry_count, setWord, guess, guessed_mask, toggle_state, reject, dropped});
  endfunction

  function automatic logic [127:0] model_vec();
    logic [39:0] w;
    logic [25:0] m;
    w = '0;
    foreach (m_word[i]) w = (w << 8) | 40'(m_word[i]);
    for (int i = 0; i < 26; i++) m[i] = m_guessed[i];
    return 128'({2'(m_phase), 3'(m_word.size()), w, m_guess, m, m_tog, m_rej, m_drop});
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit kv, input logic [7:0] k, input bit rdy, input bit busy,
                       input bit g, input bit r);
    key_valid = kv; key_data = k; game_rdy = rdy; red_busy = busy; green = g; red = r;
  endtask

  task automatic model_reset();
    m_phase = 0; m_word.delete(); m_pend = -1; m_slot = 0; m_guess = 8'h00;
    m_rej = 0; m_drop = 0; m_tog = 0;
    for (int i = 0; i < 26; i++) m_guessed[i] = 0;
  endtask

  // One clock of the game-entry rules, applied to the model.
  task automatic model_clock(input bit kv, input logic [7:0] kd, input bit rdy, input bit busy,
                             input bit g, input bit r);
    logic [7:0] k;
    bit letter, iss;
    k = kd;
    m_rej = 0; m_drop = 0; m_tog = 0;
    if (k >= 8'h61 && k <= 8'h7A) k = k - 8'h20;
    letter = (k >= 8'h41 && k <= 8'h5A);
    case (m_phase)
      0: if (kv) begin
        if (letter && m_word.size() < 5) m_word.push_back(k);
        else if (kd == 8'h08 && m_word.size() > 0) void'(m_word.pop_back());
        else if (kd == 8'h0D && m_word.size() == 5) m_phase = 1;
        else m_rej = 1;
      end
      1: begin
        m_rej = kv;
        if (rdy && !busy) begin m_tog = 1; m_slot = 0; m_phase = 2; end
      end
      2: if (g || r) begin
        m_phase = 3; m_pend = -1; m_rej = kv;
      end else begin
        iss = (m_pend >= 0) && m_slot;
        if (iss) begin m_guess = 8'(m_pend); m_pend = -1; end
        m_slot = iss ? 1'b0 : (m_slot || rdy);
        if (kv) begin
          if (letter && !m_guessed[k - 8'h41]) begin
            m_guessed[k - 8'h41] = 1;
            if (m_pend >= 0) m_drop = 1;
            m_pend = int'(k);
          end else m_rej = 1;
        end
      end
      default: m_rej = kv;
    endcase
  endtask

  task automatic key(input logic [7:0] k, input bit rdy);
    drive(1, k, rdy, 0, 0, 0);
    tick();
    drive(0, 8'h00, 0, 0, 0, 0);
  endtask

  initial begin
    vec_t vecs[17];
    logic [7:0] rk;
    bit kv, rdy, busy, g;

    vecs[0]  = '{1, "A",   0, 0, 2'd0, 3'd1, 40'h41,         0, 0};
    vecs[1]  = '{1, "B",   0, 0, 2'd0, 3'd2, 40'h4142,       0, 0};
    vecs[2]  = '{1, 8'h08, 0, 0, 2'd0, 3'd1, 40'h41,         0, 0};
    vecs[3]  = '{1, 8'h08, 0, 0, 2'd0, 3'd0, 40'h0,          0, 0};
    vecs[4]  = '{1, 8'h08, 0, 0, 2'd0, 3'd0, 40'h0,          1, 0};
    vecs[5]  = '{1, "h",   0, 0, 2'd0, 3'd1, 40'h48,         0, 0};
    vecs[6]  = '{1, "E",   0, 0, 2'd0, 3'd2, 40'h4845,       0, 0};
    vecs[7]  = '{1, "L",   0, 0, 2'd0, 3'd3, 40'h48454C,     0, 0};
    vecs[8]  = '{1, "l",   0, 0, 2'd0, 3'd4, 40'h48454C4C,   0, 0};
    vecs[9]  = '{1, 8'h0D, 0, 0, 2'd0, 3'd4, 40'h48454C4C,   1, 0};
    vecs[10] = '{1, 8'h37, 0, 0, 2'd0, 3'd4, 40'h48454C4C,   1, 0};
    vecs[11] = '{1, "o",   0, 0, 2'd0, 3'd5, 40'h48454C4C4F, 0, 0};
    vecs[12] = '{1, "Z",   0, 0, 2'd0, 3'd5, 40'h48454C4C4F, 1, 0};
    vecs[13] = '{1, 8'h0D, 1, 0, 2'd1, 3'd5, 40'h48454C4C4F, 0, 0};
    vecs[14] = '{0, 8'h00, 1, 1, 2'd1, 3'd5, 40'h48454C4C4F, 0, 0};
    vecs[15] = '{1, "X",   1, 0, 2'd2, 3'd5, 40'h48454C4C4F, 1, 1};
    vecs[16] = '{0, 8'h00, 1, 0, 2'd2, 3'd5, 40'h48454C4C4F, 0, 0};

    drive(0, 8'h00, 0, 0, 0, 0);
    rst = 1'b1;
    #12;
    check("reset_state", dut_vec(), 128'h0);
    @(negedge clk);
    rst = 1'b0;
    #4;

    // Directed table: word entry, edit limits, arming.
    for (int i = 0; i < 17; i++) begin
      drive(vecs[i].kv, vecs[i].key, vecs[i].rdy, vecs[i].busy, 0, 0);
      tick();
      check($sformatf("vec%0d", i), dut_vec(),
            128'({vecs[i].ph, vecs[i].cnt, vecs[i].word, 8'h00, 26'h0, vecs[i].tog, vecs[i].rej, 1'b0}));
    end
    drive(0, 8'h00, 0, 0, 0, 0);

    // Pacing: slot already free, so 'L' issues one edge after it is accepted.
    key("L", 0);
    check("L_mask", 128'({guess, guessed_mask}), 128'({8'h00, 26'h800}));
    tick();
    check("L_issue", 128'(guess), 128'h4C);
    key("e", 0);
    tick(); tick();
    check("E_held", 128'({guess, guessed_mask}), 128'({8'h4C, 26'h810}));
    drive(0, 8'h00, 1, 0, 0, 0);
    tick();
    check("E_rdy_edge", 128'(guess), 128'h4C);
    drive(0, 8'h00, 0, 0, 0, 0);
    tick();
    check("E_issue", 128'(guess), 128'h45);

    // Duplicate / invalid keys are refused without side effects.
    key("L", 0);   check("dup_L",  128'({reject, guess, guessed_mask}), 128'({1'b1, 8'h45, 26'h810}));
    key(8'h37, 0); check("digit",  128'({reject, guess, guessed_mask}), 128'({1'b1, 8'h45, 26'h810}));
    key(8'h0D, 0); check("enter",  128'({reject, guess, guessed_mask}), 128'({1'b1, 8'h45, 26'h810}));
    key(8'h08, 0); check("bksp",   128'({reject, guess, guessed_mask}), 128'({1'b1, 8'h45, 26'h810}));

    // Overwrite while busy.
    key("A", 0);   check("A_nodrop", 128'({dropped, guessed_mask}), 128'({1'b0, 26'h811}));
    key("B", 0);   check("B_drop",   128'({dropped, guessed_mask}), 128'({1'b1, 26'h813}));
    tick();        check("drop_once", 128'({dropped, guess}), 128'({1'b0, 8'h45}));
    drive(0, 8'h00, 1, 0, 0, 0); tick();
    drive(0, 8'h00, 0, 0, 0, 0); tick();
    check("B_issue", 128'(guess), 128'h42);

    // Key and issue on the same edge: issue takes the old pending letter, no drop.
    key("C", 0);
    drive(0, 8'h00, 1, 0, 0, 0); tick();
    key("d", 0);
    check("same_edge", 128'({guess, dropped, reject}), 128'({8'h43, 1'b0, 1'b0}));
    drive(0, 8'h00, 1, 0, 0, 0); tick();
    drive(0, 8'h00, 0, 0, 0, 0); tick();
    check("D_issue", 128'(guess), 128'h44);

    // Win discards the pending guess and locks everything.
    key("F", 0);
    drive(0, 8'h00, 0, 0, 1, 0); tick();
    check("done_phase", 128'(phase), 128'd3);
    drive(0, 8'h00, 1, 0, 0, 0); tick(); tick(); tick();
    key("G", 1);
    check("done_lock", 128'({phase, reject, guess, guessed_mask, setWord}),
          128'({2'd3, 1'b1, 8'h44, 26'h83F, 40'h48454C4C4F}));

    // Async reset in the middle of PLAY.
    rst = 1'b1; tick(); rst = 1'b0;
    key("A", 0); key("B", 0); key("C", 0); key("D", 0); key("E", 0); key(8'h0D, 0);
    drive(0, 8'h00, 1, 0, 0, 0); tick(); tick();
    key("Q", 0); tick();
    check("pre_reset", 128'({phase, guess}), 128'({2'd2, 8'h51}));
    #3 rst = 1'b1;
    #1 check("async_reset", dut_vec(), 128'h0);
    tick(); rst = 1'b0;

    // Randomized games against the model.
    for (int gm = 0; gm < 4; gm++) begin
      rst = 1'b1; model_reset(); tick(); rst = 1'b0;
      for (int c = 0; c < 400; c++) begin
        kv = ($urandom_range(0, 1) == 1);
        case ($urandom_range(0, 9))
          0, 1, 2, 3: rk = 8'(8'h41 + $urandom_range(0, 25));
          4, 5:       rk = 8'(8'h61 + $urandom_range(0, 25));
          6:          rk = 8'h08;
          7:          rk = 8'h0D;
          default:    rk = 8'($urandom_range(0, 255));
        endcase
        rdy  = ($urandom_range(0, 9) < 3);
        busy = ($urandom_range(0, 9) < 3);
        g    = (c > 150) && !kv && !((m_pend >= 0) && m_slot) && ($urandom_range(0, 99) < 2);
        drive(kv, rk, rdy, busy, g, 0);
        model_clock(kv, rk, rdy, busy, g, 0);
        tick();
        check($sformatf("rand_g%0d_c%0d", gm, c), dut_vec(), model_vec());
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
